// File: rtl/ad7928_pkg.sv
// rtl/ad7928_pkg.sv - frame layout and FSM encoding shared by the ad7928 master and responder
package ad7928_pkg;

  localparam int FRAME_LEN    = 16;
  localparam int CTRL_WRITE   = 15;
  localparam int CTRL_ADDR_HI = 12;
  localparam int CTRL_ADDR_LO = 10;
  localparam int CTRL_CODING  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_CS
  } state_t;

endpackage

// File: rtl/ad7928_spi_responder_spi_pin_sync.sv
// rtl/ad7928_spi_responder_spi_pin_sync.sv - pin synchroniser with one-cycle rise/fall pulses
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(pin);
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the pin's idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/ad7928_spi_responder.sv
// rtl/ad7928_spi_responder.sv - AD7928 ADC serial-interface emulator (SPI slave, oversampled pins)
// AD7928_RAMP_GEN_EN replaces ch_data with per-channel free-running ramp counters.
module ad7928_spi_responder
  import ad7928_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int NUM_CH      = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                CLK,
  input  logic                                rst,
  input  logic                                sclk,
  input  logic                                cs_n,
  input  logic                                din,
  output logic                                dout,
  output logic                                dout_oe,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ch_data,
  output logic [ADDR_WIDTH-1:0]               cfg_addr,
  output logic                                cfg_coding,
  output logic                                frame_done
);

  localparam int FW    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic din_lvl, din_rise, din_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(CLK), .rst(rst), .pin(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(CLK), .rst(rst), .pin(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(CLK), .rst(rst), .pin(din), .level(din_lvl), .rise(din_rise), .fall(din_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_rise, cs_lvl, din_rise, din_fall};

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FW-2:0]          frame_q, frame_d;
  logic [FRAME_LEN-1:0]   ctrl_q, ctrl_d;
  logic                   dout_q, dout_d;
  logic                   dout_oe_q, dout_oe_d;
  logic [ADDR_WIDTH-1:0]  cfg_addr_q, cfg_addr_d;
  logic                   cfg_coding_q, cfg_coding_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_start;
  logic [DATA_WIDTH-1:0]  sample;
  logic [DATA_WIDTH-1:0]  coded;

`ifdef AD7928_RAMP_GEN_EN
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [ADDR_WIDTH-1:0]             sel_q, sel_d;
  logic                              unused_ch;

  assign unused_ch = ^ch_data;
  assign sample    = ramp_q[cfg_addr_q];

  // sel_q remembers which channel the current frame returns, so the bump lands on it
  // even if this same frame rewrites cfg_addr.
  always_comb begin
    ramp_d = ramp_q;
    sel_d  = sel_q;
    if (frame_start) sel_d = cfg_addr_q;
    if (frame_done_d) ramp_d[sel_q] = ramp_q[sel_q] + DATA_WIDTH'(1);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) ramp_q[i] <= DATA_WIDTH'(i) << 8;
      sel_q <= '0;
    end else begin
      ramp_q <= ramp_d;
      sel_q  <= sel_d;
    end
  end
`else
  assign sample = ch_data[cfg_addr_q];
`endif

  // Two's-complement view of a straight-binary value is just the MSB flipped.
  always_comb begin
    coded                 = sample;
    coded[DATA_WIDTH-1]   = sample[DATA_WIDTH-1] ^ ~cfg_coding_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    ctrl_d       = ctrl_q;
    dout_d       = dout_q;
    dout_oe_d    = dout_oe_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_coding_d = cfg_coding_q;
    frame_done_d = 1'b0;
    frame_start  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          frame_start = 1'b1;
          frame_d     = {cfg_addr_q, coded};
          dout_d      = 1'b0;
          dout_oe_d   = 1'b1;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        // cs_n rising wins over a coincident sclk fall: the frame is dropped uncommitted.
        if (cs_rise) begin
          state_d   = IDLE;
          dout_d    = 1'b0;
          dout_oe_d = 1'b0;
          cnt_d     = '0;
        end else if (sclk_fall) begin
          ctrl_d  = {ctrl_q[FRAME_LEN-2:0], din_lvl};
          cnt_d   = cnt_q + CNT_W'(1);
          frame_d = {frame_q[FW-3:0], 1'b0};
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = WAIT_CS;
          else                                dout_d  = frame_q[FW-2];
        end
      end

      WAIT_CS: begin
        if (cs_rise) begin
          state_d      = IDLE;
          dout_d       = 1'b0;
          dout_oe_d    = 1'b0;
          cnt_d        = '0;
          frame_done_d = 1'b1;
          if (ctrl_q[CTRL_WRITE]) begin
            cfg_addr_d   = ADDR_WIDTH'(ctrl_q[CTRL_ADDR_HI:CTRL_ADDR_LO]);
            cfg_coding_d = ctrl_q[CTRL_CODING];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_q      <= '0;
      ctrl_q       <= '0;
      dout_q       <= 1'b0;
      dout_oe_q    <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_coding_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      ctrl_q       <= ctrl_d;
      dout_q       <= dout_d;
      dout_oe_q    <= dout_oe_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_coding_q <= cfg_coding_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = dout_oe_q;
  assign cfg_addr   = cfg_addr_q;
  assign cfg_coding = cfg_coding_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ad7928_spi_responder.sv
// tb/tb_ad7928_spi_responder.sv - directed bench with frame scoreboard for ad7928_spi_responder
module tb_ad7928_spi_responder;

  logic              CLK = 1'b0;
  logic              rst;
  logic              sclk;
  logic              cs_n;
  logic              din;
  logic              dout;
  logic              dout_oe;
  logic [7:0][11:0]  ch_data;
  logic [2:0]        cfg_addr;
  logic              cfg_coding;
  logic              frame_done;

  ad7928_spi_responder dut (
    .CLK(CLK), .rst(rst), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
    .cfg_addr(cfg_addr), .cfg_coding(cfg_coding), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          fd_cnt = 0;
  logic [15:0] exp_q[$];
  logic [2:0]  m_addr;
  logic        m_coding;
`ifdef AD7928_RAMP_GEN_EN
  logic [7:0][11:0] m_ramp;
`endif

  always @(negedge CLK) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    m_addr   = 3'd0;
    m_coding = 1'b1;
`ifdef AD7928_RAMP_GEN_EN
    for (int i = 0; i < 8; i++) m_ramp[i] = 12'(i << 8);
`endif
  endtask

  function automatic logic [15:0] model_frame();
    logic [11:0] s;
`ifdef AD7928_RAMP_GEN_EN
    s = m_ramp[m_addr];
`else
    s = ch_data[m_addr];
`endif
    if (!m_coding) s[11] = ~s[11];
    return {1'b0, m_addr, s};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, dout, 1'b0);
    chk({tag, "_dout_oe"}, dout_oe, 1'b0);
    chk({tag, "_cfg_addr"}, cfg_addr, 3'd0);
    chk({tag, "_cfg_coding"}, cfg_coding, 1'b1);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
  endtask

  // Master: sclk idles high, 10 CLK per bit, dout sampled just before each falling edge.
  task automatic xfer(input logic [15:0] word, input int nedge, input int rst_at,
                      output logic [15:0] rx);
    rx = '0;
    @(negedge CLK);
    cs_n = 1'b0;
    wait_clk(6);
    for (int k = 0; k < nedge; k++) begin
      din = word[15-k];
      wait_clk(5);
      rx = {rx[14:0], dout};
      if (k == 0) chk("dout_oe_in_frame", dout_oe, 1'b1);
      sclk = 1'b0;
      if (k == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        check_reset_outputs("midframe_rst");
        rst = 1'b0;
        model_reset();
      end
      wait_clk(5);
      sclk = 1'b1;
    end
    wait_clk(5);
    cs_n = 1'b1;
    din  = 1'b0;
  endtask

  task automatic frame(input logic [15:0] word);
    logic [15:0] rx;
    logic [15:0] e;
    int          fd0;
    exp_q.push_back(model_frame());
    fd0 = fd_cnt;
    xfer(word, 16, -1, rx);
    wait_clk(6);
    e = exp_q.pop_front();
    chk("frame_data", rx, e);
    chk("frame_done_once", fd_cnt - fd0, 1);
`ifdef AD7928_RAMP_GEN_EN
    m_ramp[e[14:12]] = m_ramp[e[14:12]] + 12'd1;
`endif
    if (word[15]) begin
      m_addr   = word[12:10];
      m_coding = word[4];
    end
    chk("cfg_addr", cfg_addr, m_addr);
    chk("cfg_coding", cfg_coding, m_coding);
  endtask

  initial begin
    logic [15:0] rx;
    int          fd0;
    rst     = 1'b1;
    sclk    = 1'b1;
    cs_n    = 1'b1;
    din     = 1'b0;
    ch_data = '0;
    model_reset();
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(4);
    check_reset_outputs("post_reset");

    ch_data[0] = 12'hABC;
    frame(16'h0000);

    ch_data[3] = 12'h123;
    frame(16'h8C10);
    frame(16'h0000);

    ch_data[3] = 12'h800;
    frame(16'h8C00);
    frame(16'h0000);

    fd0 = fd_cnt;
    xfer(16'hFFFF, 9, -1, rx);
    wait_clk(2);
    chk("abort_oe_before_latency", dout_oe, 1'b1);
    wait_clk(1);
    chk("abort_oe_after_latency", dout_oe, 1'b0);
    wait_clk(6);
    chk("abort_no_frame_done", fd_cnt - fd0, 0);
    chk("abort_cfg_addr", cfg_addr, m_addr);
    chk("abort_cfg_coding", cfg_coding, m_coding);

    fd0 = fd_cnt;
    xfer(16'h9410, 16, 6, rx);
    wait_clk(6);
    chk("rst_frame_no_done", fd_cnt - fd0, 0);
    chk("rst_frame_cfg_addr", cfg_addr, m_addr);
    frame(16'h0000);

    ch_data[2] = 12'h5A5;
    frame(16'h8810);
    frame(16'h0000);
    frame(16'h0000);
    frame(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ad7928_spi_responder.md
Name: ad7928_spi_responder

Overview:
Synthesizable emulator of the AD7928 8-channel, 12-bit ADC serial interface: the SPI slave at the far end of an ad7928 SPI master.
- Decodes the master's 16-bit control word on DIN.
- Returns a 16-bit conversion frame on DOUT: leading zero, 3-bit channel address, 12-bit sample.
- Used in loopback benches and FPGA self-test in place of the real ADC, one instance per master.
- Runs on the system clock and oversamples the SPI pins.

Parameters:
- DATA_WIDTH, 12, sample width (frame = 1 + ADDR_WIDTH + DATA_WIDTH = 16).
- NUM_CH, 8, number of emulated input channels.
- ADDR_WIDTH, 3, channel address width (clog2 of NUM_CH).
- SYNC_STAGES, 2, flip-flop stages on each SPI input pin.

Ports:
- CLK  input  1  system clock; the single clock.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master, asynchronous to CLK; idles high.
- cs_n  input  1  SPI chip select, active low.
- din  input  1  SPI data master->slave.
- dout  output  1  SPI data slave->master.
- dout_oe  output  1  high while the frame is driven (tristate model).
- ch_data  input  NUM_CH x DATA_WIDTH  per-channel analog value as straight binary.
- cfg_addr  output  ADDR_WIDTH  currently selected channel.
- cfg_coding  output  1  1 = straight binary, 0 = two's complement.
- frame_done  output  1  one-CLK pulse when a complete frame ends.

Behaviour:
Clocking and reset
- One clock (CLK); reset is asynchronous and active-high.
- Reset values: dout=0, dout_oe=0, cfg_addr=0, cfg_coding=1, frame_done=0, bit counter=0, FSM=IDLE.
- A reset asserted mid-frame aborts the frame; no control-word commit.

Input synchronisation and latency
- sclk, cs_n and din each pass through SYNC_STAGES flops, then one edge-detect register.
- A pin edge is acted on 3 CLK later with the defaults.
- Requirement: f_CLK >= 8 x f_SCLK.

FSM states: IDLE, SHIFT, WAIT_CS.
- IDLE -> SHIFT on cs_n falling edge:
  - latch frame = {1'b0, cfg_addr, coded(ch_data[cfg_addr])}, where coded() inverts the MSB when cfg_coding=0;
  - dout_oe=1; dout = frame[15] (0); bit counter = 0.
- SHIFT, each sclk falling edge:
  - din sampled into the 16-bit control shift register, MSB first; counter increments.
  - For counts 1..15, dout presents frame[15-count] in the same cycle.
  - The master samples dout on the following falling edge.
- SHIFT -> WAIT_CS when the counter reaches 16; further sclk edges are ignored and dout holds the last bit.
- WAIT_CS -> IDLE on cs_n rising edge:
  - dout_oe=0, dout=0, frame_done pulses;
  - if control bit 15 (WRITE)=1: cfg_addr <= bits 12:10, cfg_coding <= bit 4;
  - bits 14, 13, 9:5 and 3:0 are ignored.
- SHIFT -> IDLE on cs_n rising edge before 16 falling edges:
  - abort; no commit; no frame_done.
- Simultaneous sclk fall and cs_n rise in the same synchronised cycle: cs_n wins and the edge is not counted.
- Channel switching: an address written in frame N is returned in frame N+1, matching the real part's one-frame pipeline.

Optional Feature:
- Macro: AD7928_RAMP_GEN_EN.
- When defined:
  - ch_data is ignored;
  - each channel has an internal DATA_WIDTH counter, reset to channel_index << 8;
  - a channel's counter increments by 1 (wrapping 4095 -> 0) at every completed frame that returned it.
- When undefined: no counters are built and ch_data is used.

Decomposition:
- Package ad7928_pkg holds:
  - FRAME_LEN=16;
  - control-bit index localparams: CTRL_WRITE=15, CTRL_ADDR_HI=12, CTRL_ADDR_LO=10, CTRL_CODING=4;
  - enum state_t {IDLE, SHIFT, WAIT_CS}.
- Share the package with ad7928 so master and responder agree on the frame layout.
- One sub-module, spi_pin_sync: parameterised synchroniser with rise/fall pulse outputs, instantiated three times.

Test Plan:
- Reset, ch_data[0]=12'hABC, master frame with din=16'h0000 -> dout bits = 16'h0ABC; cfg_addr stays 0; frame_done pulses once.
- Frame 1 din=16'h8C10 (WRITE, ADD=3, CODING=1), ch_data[3]=12'h123 -> frame 1 returns channel 0; frame 2 returns 16'h3123; cfg_addr=3.
- din=16'h8C00 (CODING=0), ch_data[3]=12'h800 -> next frame returns 16'h3000 (MSB inverted).
- cs_n raised after 9 sclk edges with din=16'hFFFF -> no commit; cfg_addr unchanged; frame_done stays 0; dout_oe=0 3 CLK after cs_n rise.
- rst pulsed at edge 7 of a WRITE frame -> all outputs at reset values; next full frame returns channel 0 with coding=1.
- AD7928_RAMP_GEN_EN defined, 3 frames on channel 2 -> samples 12'h200, 12'h201, 12'h202.
